// File: rtl/niosii_debug_scan_pkg.sv
// rtl/niosii_debug_scan_pkg.sv - shared constants for the debug scan slave
package niosii_debug_scan_pkg;

  // Scan FSM encoding
  localparam logic [0:0] SCAN_IDLE  = 1'b0;
  localparam logic [0:0] SCAN_SHIFT = 1'b1;

  // Bit positions of the status word on ir_out and in injected capture data
  localparam int BUSY_IDX = 0;
  localparam int OVR_IDX  = 1;

  // The all-ones instruction, seen on update-IR, clears the sticky overrun flag
  function automatic logic is_clr_ovr(input logic [31:0] ir, input int ir_w);
    return ir == ((32'd1 << ir_w) - 32'd1);
  endfunction

endpackage

// File: rtl/niosii_debug_scan_slave_if.sv
// rtl/niosii_debug_scan_slave_if.sv - scan/handshake bundle between JTAG side and debug core
interface niosii_debug_scan_slave_if #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
);
  localparam int NUM_IR = 1 << IR_W;

  logic [IR_W-1:0]        ir_in;
  logic [IR_W-1:0]        ir_out;
  logic                   cdr;
  logic                   sdr;
  logic                   shift_en;
  logic                   tdi;
  logic                   tdo;
  logic                   udr;
  logic                   uir;
  logic [NUM_IR*DR_W-1:0] capture_data;
  logic [DR_W-1:0]        jdo;
  logic [NUM_IR-1:0]      take_action;
  logic [NUM_IR-1:0]      take_no_action;
  logic                   action_ack;
  logic                   busy;
  logic                   overrun;

  modport slave (
    input  ir_in, cdr, sdr, shift_en, tdi, udr, uir, capture_data, action_ack,
    output ir_out, tdo, jdo, take_action, take_no_action, busy, overrun
  );

  modport master (
    output ir_in, cdr, sdr, shift_en, tdi, udr, uir, capture_data, action_ack,
    input  ir_out, tdo, jdo, take_action, take_no_action, busy, overrun
  );
endinterface

// File: rtl/niosii_debug_scan_shifter.sv
// rtl/niosii_debug_scan_shifter.sv - data register, bit counter and capture mux
module niosii_debug_scan_shifter #(
  parameter int IR_W      = 2,
  parameter int DR_W      = 38,
  parameter int STATUS_EN = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          capture_i,
  input  logic                          shift_i,
  input  logic                          tdi_i,
  input  logic [IR_W-1:0]               ir_i,
  input  logic [(1<<IR_W)*DR_W-1:0]     capture_data_i,
  input  logic                          busy_i,
  input  logic                          overrun_i,
  output logic [DR_W-1:0]               sr_o,
  output logic                          full_o,
  output logic                          tdo_o
);
  import niosii_debug_scan_pkg::*;

  localparam int NUM_IR = 1 << IR_W;
  localparam int CNT_W  = $clog2(DR_W + 1);

  logic [DR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DR_W-1:0]  cap_word;

  // Select the capture slice for the current instruction, overlaying status bits
  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NUM_IR; k++) begin
      if (ir_i == IR_W'(k)) cap_word = capture_data_i[k*DR_W +: DR_W];
    end
    if (STATUS_EN != 0) begin
      cap_word[DR_W-1-(1-OVR_IDX)] = overrun_i;
      cap_word[DR_W-2+BUSY_IDX]    = busy_i;
    end
  end

  // Capture wins over shift; the bit counter saturates once a full word is in
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (capture_i) begin
      sr_d  = cap_word;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[DR_W-1:1]};
      if (cnt_q != CNT_W'(DR_W)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register the data word and bit count
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o   = sr_q;
  assign full_o = (cnt_q == CNT_W'(DR_W));
  assign tdo_o  = sr_q[0];

endmodule

// File: rtl/niosii_debug_scan_slave.sv
// rtl/niosii_debug_scan_slave.sv - debug scan-chain slave: FSM, update handshake, overrun
module niosii_debug_scan_slave #(
  parameter int IR_W      = 2,
  parameter int DR_W      = 38,
  parameter int ACT_BIT   = 37,
  parameter int STATUS_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  niosii_debug_scan_slave_if.slave  bus
);
  import niosii_debug_scan_pkg::*;

  localparam int NUM_IR = 1 << IR_W;

  logic [0:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic [DR_W-1:0]   jdo_q, jdo_d;
  logic [NUM_IR-1:0] ta_q, ta_d, tna_q, tna_d;
  logic [IR_W-1:0]   status;
  logic [DR_W-1:0]   sr;
  logic              full;

  logic              in_shift, udr_fire, capture, shift, busy_eff, accept, ovr_hit;
  logic [NUM_IR-1:0] ir_sel;

  // udr only acts in SHIFT and beats a same-cycle cdr; busy is judged after a same-cycle ack
  assign in_shift = (state_q == SCAN_SHIFT);
  assign udr_fire = in_shift & bus.udr;
  assign capture  = bus.cdr & ~bus.udr;
  assign shift    = in_shift & bus.sdr & bus.shift_en & ~bus.udr;
  assign busy_eff = busy_q & ~bus.action_ack;
  assign accept   = udr_fire & full & ~busy_eff;
  assign ovr_hit  = udr_fire & full & busy_eff;
  assign ir_sel   = NUM_IR'(1) << bus.ir_in;

  niosii_debug_scan_shifter #(
    .IR_W      (IR_W),
    .DR_W      (DR_W),
    .STATUS_EN (STATUS_EN)
  ) u_shifter (
    .clk            (clk),
    .reset          (reset),
    .capture_i      (capture),
    .shift_i        (shift),
    .tdi_i          (bus.tdi),
    .ir_i           (bus.ir_in),
    .capture_data_i (bus.capture_data),
    .busy_i         (busy_q),
    .overrun_i      (ovr_q),
    .sr_o           (sr),
    .full_o         (full),
    .tdo_o          (bus.tdo)
  );

  // Next-state for scan FSM, handshake flags, output word and action pulses
  always_comb begin
    state_d = state_q;
    if (udr_fire)     state_d = SCAN_IDLE;
    else if (capture) state_d = SCAN_SHIFT;

    busy_d = accept | busy_eff;

    ovr_d = ovr_q;
    if (bus.uir && is_clr_ovr(32'(bus.ir_in), IR_W)) ovr_d = 1'b0;
    if (ovr_hit) ovr_d = 1'b1;

    jdo_d = accept ? sr : jdo_q;
    ta_d  = (accept &&  sr[ACT_BIT]) ? ir_sel : '0;
    tna_d = (accept && !sr[ACT_BIT]) ? ir_sel : '0;
  end

  // Register FSM state, flags, jdo and the one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN_IDLE;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      jdo_q   <= '0;
      ta_q    <= '0;
      tna_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      jdo_q   <= jdo_d;
      ta_q    <= ta_d;
      tna_q   <= tna_d;
    end
  end

  // Pack busy/overrun into the IR status word
  always_comb begin
    status           = '0;
    status[BUSY_IDX] = busy_q;
    status[OVR_IDX]  = ovr_q;
  end

  assign bus.ir_out         = status;
  assign bus.jdo            = jdo_q;
  assign bus.take_action    = ta_q;
  assign bus.take_no_action = tna_q;
  assign bus.busy           = busy_q;
  assign bus.overrun        = ovr_q;

endmodule

// File: tb/tb_niosii_debug_scan_slave.sv
// tb/tb_niosii_debug_scan_slave.sv - scoreboard bench for the debug scan slave
module tb_niosii_debug_scan_slave;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         g_sel, g_cdr, g_sdr, g_shift, g_tdi, g_udr, g_uir, g_ack;
  logic [2:0]   g_ir;
  logic [151:0] g_cap;

  niosii_debug_scan_slave_if #(.IR_W(2), .DR_W(38)) a_if();
  niosii_debug_scan_slave_if #(.IR_W(3), .DR_W(16)) b_if();

  assign a_if.ir_in        = g_ir[1:0];
  assign a_if.cdr          = g_cdr   & ~g_sel;
  assign a_if.sdr          = g_sdr   & ~g_sel;
  assign a_if.shift_en     = g_shift & ~g_sel;
  assign a_if.tdi          = g_tdi;
  assign a_if.udr          = g_udr   & ~g_sel;
  assign a_if.uir          = g_uir   & ~g_sel;
  assign a_if.action_ack   = g_ack   & ~g_sel;
  assign a_if.capture_data = g_cap;

  assign b_if.ir_in        = g_ir;
  assign b_if.cdr          = g_cdr   & g_sel;
  assign b_if.sdr          = g_sdr   & g_sel;
  assign b_if.shift_en     = g_shift & g_sel;
  assign b_if.tdi          = g_tdi;
  assign b_if.udr          = g_udr   & g_sel;
  assign b_if.uir          = g_uir   & g_sel;
  assign b_if.action_ack   = g_ack   & g_sel;
  assign b_if.capture_data = g_cap[127:0];

  niosii_debug_scan_slave #(.IR_W(2), .DR_W(38), .ACT_BIT(37), .STATUS_EN(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  niosii_debug_scan_slave #(.IR_W(3), .DR_W(16), .ACT_BIT(15), .STATUS_EN(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  logic        o_tdo, o_busy, o_ovr;
  logic [37:0] o_jdo;
  logic [2:0]  o_irout;
  assign o_tdo   = g_sel ? b_if.tdo     : a_if.tdo;
  assign o_busy  = g_sel ? b_if.busy    : a_if.busy;
  assign o_ovr   = g_sel ? b_if.overrun : a_if.overrun;
  assign o_jdo   = g_sel ? {22'b0, b_if.jdo} : a_if.jdo;
  assign o_irout = g_sel ? b_if.ir_out  : {1'b0, a_if.ir_out};

  typedef struct {
    logic        inst;
    logic [37:0] jdo;
    logic [7:0]  ta;
    logic [7:0]  tna;
  } exp_t;
  exp_t exp_q[$];

  logic        m_busy [2];
  logic        m_ovr  [2];
  logic [37:0] m_jdo  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int dw(input logic s);
    return s ? 16 : 38;
  endfunction

  function automatic int actb(input logic s);
    return s ? 15 : 37;
  endfunction

  function automatic logic [37:0] wmask(input int n);
    return 38'((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [37:0] captured(input logic s, input logic [2:0] ir);
    logic [37:0] c;
    int w;
    w = dw(s);
    c = 38'(g_cap >> (int'(ir) * w)) & wmask(w);
    c[w-1] = m_ovr[s];
    c[w-2] = m_busy[s];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_busy"},   64'(o_busy),  64'(m_busy[g_sel]));
    chk({tag, "_ovr"},    64'(o_ovr),   64'(m_ovr[g_sel]));
    chk({tag, "_jdo"},    64'(o_jdo),   64'(m_jdo[g_sel]));
    chk({tag, "_irout"},  64'(o_irout), 64'({m_ovr[g_sel], m_busy[g_sel]}));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_busy[s] = 1'b0;
      m_ovr[s]  = 1'b0;
      m_jdo[s]  = '0;
    end
  endtask

  // One scan: optional capture, nbits shifts of word (LSB first), then udr with optional ack
  task automatic scan(input logic s, input logic [2:0] ir, input int nbits,
                      input logic [37:0] word, input logic ack, input logic do_cap);
    logic [37:0] cap, got;
    logic        full, beff;
    exp_t        e;
    int          w;
    w     = dw(s);
    g_sel = s;
    g_ir  = ir;
    cap   = captured(s, ir);
    if (do_cap) begin
      g_cdr = 1'b1; tick(); g_cdr = 1'b0;
    end
    g_sdr = 1'b1;
    got   = '0;
    for (int i = 0; i < nbits; i++) begin
      got[i]  = o_tdo;
      g_tdi   = word[i];
      g_shift = 1'b1; tick(); g_shift = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    g_sdr = 1'b0;
    if (do_cap) chk("tdo_stream", 64'(got & wmask(nbits)), 64'(cap & wmask(nbits)));

    full      = do_cap && (nbits == w);
    beff      = m_busy[s] & ~ack;
    m_busy[s] = beff;
    if (full) begin
      if (beff) m_ovr[s] = 1'b1;
      else begin
        e.inst = s;
        e.jdo  = word & wmask(w);
        e.ta   = word[actb(s)] ? (8'd1 << ir) : 8'd0;
        e.tna  = word[actb(s)] ? 8'd0 : (8'd1 << ir);
        exp_q.push_back(e);
        m_jdo[s]  = e.jdo;
        m_busy[s] = 1'b1;
      end
    end
    g_udr = 1'b1; g_ack = ack; tick(); g_udr = 1'b0; g_ack = 1'b0;
    check_state("udr");
    tick();
  endtask

  task automatic ack_pulse(input logic s);
    g_sel = s;
    g_ack = 1'b1; tick(); g_ack = 1'b0;
    m_busy[s] = 1'b0;
    chk("ack_busy", 64'(o_busy), 64'(0));
  endtask

  task automatic uir_pulse(input logic s, input logic [2:0] ir);
    g_sel = s;
    g_ir  = ir;
    g_uir = 1'b1; tick(); g_uir = 1'b0;
    if (int'(ir) == (s ? 7 : 3)) m_ovr[s] = 1'b0;
    chk("uir_ovr", 64'(o_ovr), 64'(m_ovr[s]));
  endtask

  // Monitor: every action pulse must match the oldest pending accepted update
  logic        mon_a, mon_b, mon_inst;
  logic [37:0] mon_jdo;
  logic [7:0]  mon_ta, mon_tna;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      mon_a = (|a_if.take_action) | (|a_if.take_no_action);
      mon_b = (|b_if.take_action) | (|b_if.take_no_action);
      if (mon_a || mon_b) begin
        mon_inst = mon_b;
        mon_jdo  = mon_b ? {22'b0, b_if.jdo} : a_if.jdo;
        mon_ta   = mon_b ? b_if.take_action    : {4'b0, a_if.take_action};
        mon_tna  = mon_b ? b_if.take_no_action : {4'b0, a_if.take_no_action};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected: got ta=0x%0h tna=0x%0h, expected no pulse", mon_ta, mon_tna);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_inst",   64'(mon_inst), 64'(mon_e.inst));
          chk("pulse_jdo",    64'(mon_jdo),  64'(mon_e.jdo));
          chk("pulse_ta",     64'(mon_ta),   64'(mon_e.ta));
          chk("pulse_tna",    64'(mon_tna),  64'(mon_e.tna));
          chk("pulse_single", 64'($countones({mon_ta, mon_tna, mon_a, mon_b})), 64'(2));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] w;
    logic        s;
    logic [2:0]  ir;
    int          nb;
    {g_sel, g_cdr, g_sdr, g_shift, g_tdi, g_udr, g_uir, g_ack} = '0;
    g_ir  = '0;
    g_cap = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    reset = 1'b1;
    tick();
    do_reset();

    for (int i = 0; i < 2; i++) begin
      g_sel = i[0];
      #1;
      check_state("reset");
      chk("reset_tdo", 64'(o_tdo), 64'(0));
    end

    // Directed, wide instance
    g_cap[2*38 +: 38] = 38'h15_5555_5555;
    scan(1'b0, 3'd2, 38, 38'h20_0000_00AB, 1'b0, 1'b1);
    scan(1'b0, 3'd2, 37, 38'h3F_1234_5678, 1'b0, 1'b1);
    scan(1'b0, 3'd2, 38, 38'h0A_DEAD_BEEF, 1'b0, 1'b1);
    uir_pulse(1'b0, 3'd1);
    uir_pulse(1'b0, 3'd3);
    scan(1'b0, 3'd1, 38, 38'h25_0F0F_0F0F, 1'b1, 1'b1);
    ack_pulse(1'b0);
    scan(1'b0, 3'd1, 38, 38'h1F_FFFF_0001, 1'b0, 1'b1);
    scan(1'b0, 3'd3, 36, 38'h00_0000_0000, 1'b0, 1'b1);
    ack_pulse(1'b0);

    // Directed, narrow instance
    g_cap[2*16 +: 16] = 16'h5555;
    scan(1'b1, 3'd2, 16, 38'h80AB, 1'b0, 1'b1);
    scan(1'b1, 3'd6, 16, 38'h1234, 1'b0, 1'b1);
    uir_pulse(1'b1, 3'd7);
    ack_pulse(1'b1);

    // Randomized traffic on both instances
    for (int n = 0; n < 30; n++) begin
      s     = 1'($urandom_range(0, 1));
      ir    = s ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      nb    = ($urandom_range(0, 3) == 0) ? dw(s) - 1 - $urandom_range(0, 3) : dw(s);
      w     = 38'({$urandom(), $urandom()});
      g_cap = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      scan(s, ir, nb, w, 1'($urandom_range(0, 1)), 1'b1);
      case ($urandom_range(0, 3))
        0: ack_pulse(s);
        1: uir_pulse(s, s ? 3'($urandom_range(6, 7)) : 3'($urandom_range(2, 3)));
        default: ;
      endcase
    end

    // Reset during a pending update and mid-shift
    ack_pulse(1'b0);
    scan(1'b0, 3'd0, 38, 38'h21_0000_0042, 1'b0, 1'b1);
    g_sel = 1'b0;
    g_ir  = 3'd0;
    g_cdr = 1'b1; tick(); g_cdr = 1'b0;
    g_sdr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      g_tdi = 1'($urandom_range(0, 1));
      g_shift = 1'b1; tick(); g_shift = 1'b0;
    end
    g_sdr = 1'b0;
    do_reset();
    check_state("post_reset");
    scan(1'b0, 3'd0, 38, 38'h3F_FFFF_FFFF, 1'b0, 1'b0);

    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/niosii_debug_scan_slave.md
# niosii_debug_scan_slave

Parametrised, single-clock debug scan-chain slave for the Nios II debug path. It takes virtual-JTAG state strobes, already synchronised into the `clk` domain, and performs the capture/shift/update of a DR_W-bit data register selected by an IR_W-bit instruction. It presents the updated word on `jdo` with one-cycle per-instruction action/no-action pulses. It adds an acknowledge handshake, sticky overrun detection, short-scan rejection and optional status injection into captured data.

## Interface
Parameters:
- IR_W, 2, instruction width; NUM_IR = 2**IR_W (derived, not overridable); IR_W ≥ 2
- DR_W, 38, data register / jdo width; DR_W ≥ 4
- ACT_BIT, 37, bit of the shifted word selecting action vs no-action; < DR_W
- STATUS_EN, 1, when 1 captured word bits [DR_W-1:DR_W-2] are replaced by {overrun, busy}

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ir_in  in  IR_W  current virtual IR
- ir_out  out  IR_W  status: bit0 busy, bit1 overrun, others 0
- cdr  in  1  capture-DR strobe, one-cycle pulse
- sdr  in  1  shift-DR state, level
- shift_en  in  1  one-cycle pulse per JTAG bit
- tdi  in  1  serial in
- tdo  out  1  serial out = sr[0]
- udr  in  1  update-DR strobe, one-cycle pulse
- uir  in  1  update-IR strobe, one-cycle pulse
- capture_data  in  NUM_IR*DR_W  capture value, slice k for instruction k
- jdo  out  DR_W  last accepted scan word
- take_action  out  NUM_IR  one-hot pulse, ACT_BIT set
- take_no_action  out  NUM_IR  one-hot pulse, ACT_BIT clear
- action_ack  in  1  consumer done with jdo
- busy  out  1  update accepted, not yet acknowledged
- overrun  out  1  sticky: update arrived while busy

## Operation
- Scan FSM states: IDLE, SHIFT.
- IDLE + cdr: sr ← capture_data slice ir_in (status-injected if STATUS_EN), bit_cnt ← 0, → SHIFT.
- SHIFT + cdr: recapture as above, stay SHIFT.
- SHIFT + sdr & shift_en: sr ← {tdi, sr[DR_W-1:1]}; bit_cnt increments, saturating at DR_W.
- SHIFT + udr, evaluated with busy after same-cycle ack:
  - bit_cnt ≠ DR_W: short scan, no update, no pulse, → IDLE.
  - busy: overrun ← 1, jdo unchanged, no pulse, → IDLE.
  - else: jdo ← sr; take_action[ir_in] if sr[ACT_BIT] else take_no_action[ir_in]; busy ← 1; → IDLE.
- IDLE + udr or shift_en: ignored.
- action_ack: busy ← 0; ack with busy low is a no-op.
- uir with ir_in all-ones: overrun ← 0.
- Simultaneous cdr and udr: udr takes precedence, cdr dropped.
- Simultaneous udr and uir: both take effect.
- At most one bit of take_action | take_no_action is set per cycle.

## Timing
- Reset values: sr, jdo, bit_cnt, take_*, busy, overrun = 0; state IDLE; tdo = 0; ir_out = 0.
- Capture: sr valid, and tdo = new sr[0], one cycle after cdr.
- Shift: one bit per shift_en; tdo updates the cycle after the pulse.
- Update latency: jdo, take_* pulse and busy rise one cycle after udr; pulse width exactly one cycle.
- ack: busy low one cycle after action_ack.
- ack and udr in the same cycle: busy stays 1 (new update), no overrun.
- Reset mid-scan or mid-pending: all state cleared next cycle; no pulse emitted.
- Back-to-back udr spacing: one cycle minimum, with ack each time.

## Structure
- Package niosii_debug_scan_pkg: scan state enum, status bit indices (BUSY_IDX=0, OVR_IDX=1), clear-overrun opcode rule.
- Sub-module niosii_debug_scan_shifter: sr, bit_cnt, capture mux, status injection, tdo. Top keeps FSM, busy/overrun, jdo, pulse decode.

## Test plan
- Full scan, IR=2, capture 0x15_5555_5555, shift 38 bits of 0x20_0000_00AB, udr → capture bits serialised on tdo LSB-first; jdo = 0x20_0000_00AB; take_action = 4'b0100 for one cycle; busy = 1.
- Short scan: 37 shift_en then udr → jdo unchanged, no pulse, busy unchanged.
- Overrun: second full scan + udr without ack → overrun = 1, ir_out = 2'b11, jdo holds first word. uir with ir_in = 2'b11 → overrun = 0.
- ack and udr in the same cycle with busy = 1 → update accepted, overrun stays 0, busy = 1.
- ACT_BIT clear, IR=1 → take_no_action = 4'b0010. With STATUS_EN = 1 and busy = 1, captured bits [37:36] = 2'b01.
- reset asserted mid-shift (bit 20) then udr → no pulse; jdo = 0, state IDLE. Non-default IR_W = 3, DR_W = 16 instance runs the first scenario scaled.
